bisr_ru_allocator: RTL and testbench

//  Configures the recompute units (RUs) of the BISR systolic array from a BIST fault map.

---
 rtl/bisr_ru_allocator_if.sv | 32 +++
 rtl/bisr_ru_allocator.sv | 119 +++++++++++
 tb/tb_bisr_ru_allocator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bisr_ru_allocator_if.sv
// Request/result bundle between the BIST fault collector, the RU allocator and its consumers.
// The master drives a fault map and start pulse; the slave returns the RU binding.
interface bisr_ru_allocator_if #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int NUM_RU        = 2,
    parameter int NUM_BITS_ROWS = $clog2(ROWS),
    parameter int NUM_BITS_COLS = $clog2(COLS)
);
    logic                              start;
    logic [ROWS*COLS-1:0]              fault_map;
    logic                              alloc_busy;
    logic                              alloc_done;
    logic [NUM_RU-1:0]                 ru_en;
    logic [NUM_BITS_ROWS*NUM_RU-1:0]   ru_row_mapping;
    logic [NUM_BITS_COLS*NUM_RU-1:0]   ru_col_mapping;
    logic [ROWS*COLS-1:0]              pe_bypass;
    logic                              unrepairable;
    logic [$clog2(ROWS*COLS+1)-1:0]    num_faults;

    modport master (
        output start, fault_map,
        input  alloc_busy, alloc_done, ru_en, ru_row_mapping, ru_col_mapping,
               pe_bypass, unrepairable, num_faults
    );

    modport slave (
        input  start, fault_map,
        output alloc_busy, alloc_done, ru_en, ru_row_mapping, ru_col_mapping,
               pe_bypass, unrepairable, num_faults
    );
endinterface

// File: rtl/bisr_ru_allocator.sv
// Binds each faulty PE of the BISR array, in row-major order, to the next free recompute unit.
// Scans one PE per clock from a shadow copy of the fault map taken on start.
module bisr_ru_allocator #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int NUM_RU        = 2,
    parameter int NUM_BITS_ROWS = $clog2(ROWS),
    parameter int NUM_BITS_COLS = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    bisr_ru_allocator_if.slave    bus
);
    localparam int NPE   = ROWS * COLS;
    localparam int IDX_W = $clog2(NPE);
    localparam int NF_W  = $clog2(NPE + 1);
    localparam int RP_W  = $clog2(NUM_RU + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                      state;
    logic [NPE-1:0]                  shadow;
    logic [NUM_BITS_ROWS-1:0]        row_idx;
    logic [NUM_BITS_COLS-1:0]        col_idx;
    logic [IDX_W-1:0]                pe_idx;
    logic [RP_W-1:0]                 ru_ptr;
    logic                            alloc_busy;
    logic                            alloc_done;
    logic [NUM_RU-1:0]               ru_en;
    logic [NUM_BITS_ROWS*NUM_RU-1:0] ru_row_mapping;
    logic [NUM_BITS_COLS*NUM_RU-1:0] ru_col_mapping;
    logic [NPE-1:0]                  pe_bypass;
    logic                            unrepairable;
    logic [NF_W-1:0]                 num_faults;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            shadow         <= '0;
            row_idx        <= '0;
            col_idx        <= '0;
            pe_idx         <= '0;
            ru_ptr         <= '0;
            alloc_busy     <= 1'b0;
            alloc_done     <= 1'b0;
            ru_en          <= '0;
            ru_row_mapping <= '0;
            ru_col_mapping <= '0;
            pe_bypass      <= '0;
            unrepairable   <= 1'b0;
            num_faults     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shadow         <= bus.fault_map;
                        row_idx        <= '0;
                        col_idx        <= '0;
                        pe_idx         <= '0;
                        ru_ptr         <= '0;
                        ru_en          <= '0;
                        ru_row_mapping <= '0;
                        ru_col_mapping <= '0;
                        pe_bypass      <= '0;
                        unrepairable   <= 1'b0;
                        num_faults     <= '0;
                        alloc_busy     <= 1'b1;
                        alloc_done     <= 1'b0;
                        state          <= SCAN;
                    end
                end
                SCAN: begin
                    if (shadow[pe_idx]) begin
                        if (num_faults != NF_W'(NPE))
                            num_faults <= num_faults + 1'b1;
                        if (ru_ptr < RP_W'(NUM_RU)) begin
                            // Loop instead of a variable part-select keeps index widths exact.
                            for (int unsigned k = 0; k < NUM_RU; k++) begin
                                if (ru_ptr == RP_W'(k)) begin
                                    ru_en[k] <= 1'b1;
                                    ru_row_mapping[k*NUM_BITS_ROWS +: NUM_BITS_ROWS] <= row_idx;
                                    ru_col_mapping[k*NUM_BITS_COLS +: NUM_BITS_COLS] <= col_idx;
                                end
                            end
                            pe_bypass[pe_idx] <= 1'b1;
                            ru_ptr            <= ru_ptr + 1'b1;
                        end else begin
                            unrepairable <= 1'b1;
                        end
                    end
                    pe_idx <= pe_idx + 1'b1;
                    if (col_idx == NUM_BITS_COLS'(COLS - 1)) begin
                        col_idx <= '0;
                        row_idx <= row_idx + 1'b1;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                    if (row_idx == NUM_BITS_ROWS'(ROWS - 1) && col_idx == NUM_BITS_COLS'(COLS - 1)) begin
                        alloc_busy <= 1'b0;
                        alloc_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alloc_busy     = alloc_busy;
    assign bus.alloc_done     = alloc_done;
    assign bus.ru_en          = ru_en;
    assign bus.ru_row_mapping = ru_row_mapping;
    assign bus.ru_col_mapping = ru_col_mapping;
    assign bus.pe_bypass      = pe_bypass;
    assign bus.unrepairable   = unrepairable;
    assign bus.num_faults     = num_faults;
endmodule

// File: tb/tb_bisr_ru_allocator.sv
// Directed bench for the 4x4, 2-RU allocator: reset, allocation patterns, overflow, restart
// and mid-scan reset, with hand-computed expected bindings.
module tb_bisr_ru_allocator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   n;

    bisr_ru_allocator_if #(.ROWS(4), .COLS(4), .NUM_RU(2)) bus ();

    bisr_ru_allocator #(.ROWS(4), .COLS(4), .NUM_RU(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_scan(input logic [15:0] map);
        @(negedge clk);
        bus.fault_map = map;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts edges after the start edge until alloc_done, bounded at 40.
    task automatic wait_done(input int n0, output int cnt);
        cnt = n0;
        while (!bus.alloc_done && cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] en, input logic [3:0] rows,
                                 input logic [3:0] cols, input logic [15:0] byp,
                                 input logic unrep, input logic [4:0] nf);
        @(negedge clk);
        check({tag, "_done"},  64'(bus.alloc_done), 64'd1);
        check({tag, "_busy"},  64'(bus.alloc_busy), 64'd0);
        check({tag, "_ru_en"}, 64'(bus.ru_en), 64'(en));
        check({tag, "_rows"},  64'(bus.ru_row_mapping), 64'(rows));
        check({tag, "_cols"},  64'(bus.ru_col_mapping), 64'(cols));
        check({tag, "_byp"},   64'(bus.pe_bypass), 64'(byp));
        check({tag, "_unrep"}, 64'(bus.unrepairable), 64'(unrep));
        check({tag, "_nf"},    64'(bus.num_faults), 64'(nf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(bus.alloc_busy), 64'd0);
        check({tag, "_done"},  64'(bus.alloc_done), 64'd0);
        check({tag, "_ru_en"}, 64'(bus.ru_en), 64'd0);
        check({tag, "_rows"},  64'(bus.ru_row_mapping), 64'd0);
        check({tag, "_cols"},  64'(bus.ru_col_mapping), 64'd0);
        check({tag, "_byp"},   64'(bus.pe_bypass), 64'd0);
        check({tag, "_unrep"}, 64'(bus.unrepairable), 64'd0);
        check({tag, "_nf"},    64'(bus.num_faults), 64'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.fault_map = '0;

        // 1) reset with random inputs
        repeat (2) begin
            @(negedge clk);
            bus.start     = 1'($urandom_range(0, 1));
            bus.fault_map = 16'($urandom);
        end
        @(negedge clk);
        check_all_zero("rst");
        bus.start = 1'b0;
        rst       = 1'b1;

        // 2) single fault at PE(1,2)
        start_scan(16'h0040);
        check("t2_busy_after_start", 64'(bus.alloc_busy), 64'd1);
        wait_done(0, n);
        check("t2_latency", 64'(n), 64'd16);
        check_outputs("t2", 2'b01, 4'h1, 4'h2, 16'h0040, 1'b0, 5'd1);

        // 3) two faults, PE(0,3) then PE(3,0); restart from DONE
        start_scan(16'h1008);
        check("t3_done_cleared", 64'(bus.alloc_done), 64'd0);
        wait_done(0, n);
        check("t3_latency", 64'(n), 64'd16);
        check_outputs("t3", 2'b11, 4'hC, 4'h3, 16'h1008, 1'b0, 5'd2);

        // 4) three faults overflow two RUs
        start_scan(16'h8021);
        wait_done(0, n);
        check("t4_latency", 64'(n), 64'd16);
        check_outputs("t4", 2'b11, 4'h4, 4'h4, 16'h0021, 1'b1, 5'd3);

        // 5) fault_map change and start during SCAN are ignored
        start_scan(16'h0040);
        n = 0;
        repeat (2) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus.fault_map = 16'hFFFF;
        bus.start     = 1'b1;
        @(posedge clk);
        n++;
        #1 bus.start = 1'b0;
        wait_done(n, n);
        check("t5_latency", 64'(n), 64'd16);
        check_outputs("t5", 2'b01, 4'h1, 4'h2, 16'h0040, 1'b0, 5'd1);

        // 6) reset at the 5th scan cycle, then an empty map
        start_scan(16'h0021);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t6_rst");
        rst = 1'b1;
        start_scan(16'h0000);
        wait_done(0, n);
        check("t6_latency", 64'(n), 64'd16);
        check_outputs("t6", 2'b00, 4'h0, 4'h0, 16'h0000, 1'b0, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
